operand_bank_nxn: RTL and testbench
===================================

# operand_bank_nxn

Parametrised operand store for the matrix-multiply accelerator: buffers one N×N weight matrix W and one N×N input matrix X, loaded serially, then streams them to the PE array as N per-step vectors (column k of W, row k of X). It replaces the fixed 3×3 bank with a handshaked, state-machine-controlled block. It can retain W across several X matrices, and it reports full, overflow and completion status.

## Interface
- N, 3, matrix dimension (≥2); each memory holds N*N words
- DATA_W, 4, element width in bits
- KEEP_W, 0, 1 = W memory and W count survive an unload pass; 0 = both matrices re-arm after unload
- clk  in  1  single clock, rising edge
- clear_n  in  1  reset, asynchronous, active-low
- data_in  in  DATA_W  element to write
- load_w  in  1  write data_in to next W slot (row-major)
- load_x  in  1  write data_in to next X slot (row-major)
- flush  in  1  synchronous clear of both memories, counters and flags
- unload  in  1  request one N-step unload pass
- load_ready  out  1  block accepts loads (state FILL)
- w_full, x_full  out  1  N*N words held in W / X
- start  out  1  both matrices full, unload may be issued (state READY)
- overflow  out  1  one-cycle pulse: load dropped
- data_outw  out  N*DATA_W  lane i at [i*DATA_W +: DATA_W] = W[i][k]
- data_outx  out  N*DATA_W  lane i at [i*DATA_W +: DATA_W] = X[k][i]
- out_valid  out  1  data_out* hold step k
- step  out  $clog2(N)  current k while out_valid
- unload_done  out  1  one-cycle pulse on the cycle after the last step

## Operation
- Storage: W[r][c] at address r*N+c, and the same layout for X. Counters w_cnt and x_cnt run 0..N*N and saturate at N*N.
- States: FILL, READY, UNLOAD. The reset state is FILL.
- FILL: a load is accepted on a clock edge when the target count is below N*N.
  - The accepted word is written at the counter address and the counter is incremented.
  - If load_w and load_x are both high, W takes priority. The X word is dropped and overflow pulses.
  - A load to a full matrix is dropped, that matrix is unchanged, and overflow pulses.
  - The block moves to READY when both counts equal N*N.
- READY: start=1, load_ready=0. Loads are dropped and overflow pulses. On unload=1 the block moves to UNLOAD with k=0.
- UNLOAD: one step per cycle, k=0..N-1.
  - Each step registers data_outw lane i = W[i][k] and data_outx lane i = X[k][i], with out_valid=1 and step=k.
  - After step N-1 the block moves to FILL and pulses unload_done.
  - KEEP_W=0: both counts clear to 0.
  - KEEP_W=1: only x_cnt clears. W stays full, so loading a new X alone reaches READY.
  - Memory contents are not erased by re-arming; they are overwritten by later loads.
  - unload and all loads are ignored in this state, and those loads pulse overflow.
- unload outside READY: ignored, no flag raised.
- flush (any state, highest synchronous priority):
  - zeroes all memory words, both counters, start and all outputs;
  - aborts an unload pass without pulsing unload_done;
  - moves the block to FILL.
- Reset (clear_n=0) has the same effect as flush but acts immediately and asynchronously.
- When out_valid=0, data_outw, data_outx and step are driven to 0.

## Timing
- Reset values: load_ready=1; every other output 0.
- Write latency: a word sampled at edge t is readable by unload from edge t+1.
- w_full, x_full and start are registered. Each asserts in the cycle after the edge that accepted the completing word.
- Unload latency: with unload sampled at edge t in READY, step 0 is visible after edge t+1. Steps follow on consecutive cycles, so out_valid is high for exactly N cycles.
- unload_done is high in the cycle after step N-1. load_ready is also 1 in that cycle.
- Minimum pass time: N*N loads per fill + 1 cycle for start + N unload cycles.
- The next fill may begin in the unload_done cycle.
- overflow is registered: it is high in the cycle after the edge at which the load was dropped.

## Test plan
- N=3, DATA_W=4, KEEP_W=0: load W=1..9, then X=9..1, then unload. Required responses:
  - start goes to 1 the cycle after the 18th load;
  - step0: data_outw=12'h741, data_outx=12'h789;
  - step1: 12'h852 / 12'h456;
  - step2: 12'h963 / 12'h123;
  - then unload_done=1, w_full=0, x_full=0.
- Tenth load_w after W is full (value 4'hF) → overflow pulses, W unchanged, w_cnt stays 9.
- load_w=load_x=1 with data_in=4'h5 in FILL → W gets 5, x_cnt unchanged, overflow pulses.
- KEEP_W=1: first pass as in scenario 1, then load X=1..9 only, then unload. Required responses:
  - start is reached without reloading W;
  - step0 outputs data_outw=12'h741, data_outx=12'h321.
- unload issued in FILL with W and X half-filled → no out_valid, state stays FILL.
- Mid-unload events:
  - flush at step1 → outputs are 0 in the next cycle, unload_done never pulses, all counts 0, load_ready=1;
  - repeat the pass with clear_n pulled low at step1 → same result immediately.

Source files
------------

// File: rtl/operand_bank_nxn.sv
// Operand store for the matrix-multiply array: serially loads an NxN weight matrix W
// and an NxN input matrix X, then streams column k of W and row k of X for k = 0..N-1.
module operand_bank_nxn #(
  parameter int N      = 3,
  parameter int DATA_W = 4,
  parameter int KEEP_W = 0
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  load_w,
  input  logic                  load_x,
  input  logic                  flush,
  input  logic                  unload,
  output logic                  load_ready,
  output logic                  w_full,
  output logic                  x_full,
  output logic                  start,
  output logic                  overflow,
  output logic [N*DATA_W-1:0]   data_outw,
  output logic [N*DATA_W-1:0]   data_outx,
  output logic                  out_valid,
  output logic [$clog2(N)-1:0]  step,
  output logic                  unload_done
);

  localparam int NN = N * N;
  localparam int CW = $clog2(NN + 1);
  localparam int AW = $clog2(NN);
  localparam int KW = $clog2(N + 1);
  localparam int SW = $clog2(N);
  localparam logic [CW-1:0] NN_C = CW'(NN);
  localparam logic [KW-1:0] N_K  = KW'(N);

  typedef enum logic [1:0] {FILL, READY, UNLOAD} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       w_cnt_q, w_cnt_d, x_cnt_q, x_cnt_d;
  logic [KW-1:0]       k_q, k_d;
  logic [N*DATA_W-1:0] outw_q, outw_d, outx_q, outx_d;
  logic [SW-1:0]       step_q, step_d;
  logic                valid_q, valid_d, done_q, done_d, ovf_q, ovf_d;
  logic                w_we, x_we;
  logic [DATA_W-1:0]   w_mem_q [NN];
  logic [DATA_W-1:0]   x_mem_q [NN];

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    w_cnt_d = w_cnt_q;
    x_cnt_d = x_cnt_q;
    k_d     = k_q;
    w_we    = 1'b0;
    x_we    = 1'b0;
    ovf_d   = 1'b0;
    done_d  = 1'b0;
    valid_d = 1'b0;
    outw_d  = '0;
    outx_d  = '0;
    step_d  = '0;
    if (flush) begin
      state_d = FILL;
      w_cnt_d = '0;
      x_cnt_d = '0;
      k_d     = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          // W wins a simultaneous load; the X word is always dropped in that case.
          if (load_w) begin
            if (w_cnt_q < NN_C) begin
              w_we    = 1'b1;
              w_cnt_d = w_cnt_q + CW'(1);
            end else begin
              ovf_d = 1'b1;
            end
            if (load_x) ovf_d = 1'b1;
          end else if (load_x) begin
            if (x_cnt_q < NN_C) begin
              x_we    = 1'b1;
              x_cnt_d = x_cnt_q + CW'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
          if (w_cnt_d == NN_C && x_cnt_d == NN_C) state_d = READY;
        end
        READY: begin
          ovf_d = load_w | load_x;
          if (unload) begin
            state_d = UNLOAD;
            k_d     = '0;
          end
        end
        UNLOAD: begin
          ovf_d = load_w | load_x;
          if (k_q < N_K) begin
            valid_d = 1'b1;
            step_d  = k_q[SW-1:0];
            for (int i = 0; i < N; i++) begin
              outw_d[i*DATA_W +: DATA_W] = w_mem_q[AW'(i*N + int'(k_q))];
              outx_d[i*DATA_W +: DATA_W] = x_mem_q[AW'(int'(k_q)*N + i)];
            end
            k_d = k_q + KW'(1);
          end else begin
            // Drain cycle after the last step: re-arm the counters and hand back to FILL.
            done_d  = 1'b1;
            state_d = FILL;
            k_d     = '0;
            x_cnt_d = '0;
            if (KEEP_W == 0) w_cnt_d = '0;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= FILL;
      w_cnt_q <= '0;
      x_cnt_q <= '0;
      k_q     <= '0;
      outw_q  <= '0;
      outx_q  <= '0;
      step_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_cnt_q <= w_cnt_d;
      x_cnt_q <= x_cnt_d;
      k_q     <= k_d;
      outw_q  <= outw_d;
      outx_q  <= outx_d;
      step_q  <= step_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: the memories are small flop arrays and must read as zero after reset or flush,
  // so they are reset here rather than left uninitialised like a RAM macro.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < NN; i++) begin
        w_mem_q[i] <= '0;
        x_mem_q[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NN; i++) begin
        w_mem_q[i] <= '0;
        x_mem_q[i] <= '0;
      end
    end else begin
      if (w_we) w_mem_q[w_cnt_q[AW-1:0]] <= data_in;
      if (x_we) x_mem_q[x_cnt_q[AW-1:0]] <= data_in;
    end
  end

  assign load_ready  = (state_q == FILL);
  assign start       = (state_q == READY);
  assign w_full      = (w_cnt_q == NN_C);
  assign x_full      = (x_cnt_q == NN_C);
  assign overflow    = ovf_q;
  assign data_outw   = outw_q;
  assign data_outx   = outx_q;
  assign out_valid   = valid_q;
  assign step        = step_q;
  assign unload_done = done_q;

endmodule

// File: tb/tb_operand_bank_nxn.sv
// Bench for operand_bank_nxn: one KEEP_W=0 and one KEEP_W=1 instance share stimulus and
// are compared every cycle against a matrix/queue reference model.
module tb_operand_bank_nxn;

  localparam int N  = 3;
  localparam int DW = 4;
  localparam int NN = N * N;
  localparam int SW = $clog2(N);
  localparam int VW = N * DW;

  logic          clk = 1'b0;
  logic          clear_n = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          load_w = 1'b0, load_x = 1'b0, flush = 1'b0, unload = 1'b0;

  logic          lr [2], wf [2], xf [2], st [2], ov [2], ovl [2], dn [2];
  logic [VW-1:0] dw [2], dx [2];
  logic [SW-1:0] sp [2];

  operand_bank_nxn #(.N(N), .DATA_W(DW), .KEEP_W(0)) dut_a (
    .clk(clk), .clear_n(clear_n), .data_in(data_in), .load_w(load_w), .load_x(load_x),
    .flush(flush), .unload(unload), .load_ready(lr[0]), .w_full(wf[0]), .x_full(xf[0]),
    .start(st[0]), .overflow(ov[0]), .data_outw(dw[0]), .data_outx(dx[0]),
    .out_valid(ovl[0]), .step(sp[0]), .unload_done(dn[0]));

  operand_bank_nxn #(.N(N), .DATA_W(DW), .KEEP_W(1)) dut_b (
    .clk(clk), .clear_n(clear_n), .data_in(data_in), .load_w(load_w), .load_x(load_x),
    .flush(flush), .unload(unload), .load_ready(lr[1]), .w_full(wf[1]), .x_full(xf[1]),
    .start(st[1]), .overflow(ov[1]), .data_outw(dw[1]), .data_outx(dx[1]),
    .out_valid(ovl[1]), .step(sp[1]), .unload_done(dn[1]));

  always #5 clk = ~clk;

  // Reference model: matrices, fill counts, a ready flag and a queue of the output
  // vectors still owed by an unload pass (one entry per future cycle).
  typedef struct {
    bit          valid;
    logic [VW-1:0] w;
    logic [VW-1:0] x;
    int          stp;
    bit          done;
  } exp_t;

  logic [DW-1:0] wm [2][NN];
  logic [DW-1:0] xm [2][NN];
  int            wc [2], xc [2];
  bit            rdy [2];
  bit            ovf_e [2];
  exp_t          cur [2];
  exp_t          pq [2][$];

  int checks = 0;
  int failures = 0;

  function automatic exp_t idle_out();
    exp_t e;
    e.valid = 1'b0; e.w = '0; e.x = '0; e.stp = 0; e.done = 1'b0;
    return e;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < NN; a++) begin wm[m][a] = '0; xm[m][a] = '0; end
      wc[m] = 0; xc[m] = 0; rdy[m] = 1'b0; ovf_e[m] = 1'b0;
      cur[m] = idle_out();
      pq[m].delete();
    end
  endtask

  task automatic model_edge(input bit lw, input bit lx, input bit fl, input bit un,
                            input logic [DW-1:0] d);
    for (int m = 0; m < 2; m++) begin
      ovf_e[m] = 1'b0;
      cur[m]   = idle_out();
      if (fl) begin
        for (int a = 0; a < NN; a++) begin wm[m][a] = '0; xm[m][a] = '0; end
        wc[m] = 0; xc[m] = 0; rdy[m] = 1'b0;
        pq[m].delete();
      end else if (pq[m].size() > 0) begin
        ovf_e[m] = lw | lx;
        cur[m] = pq[m].pop_front();
        if (cur[m].done) begin
          xc[m] = 0;
          if (m == 0) wc[m] = 0;
        end
      end else if (rdy[m]) begin
        ovf_e[m] = lw | lx;
        if (un) begin
          rdy[m] = 1'b0;
          for (int k = 0; k < N; k++) begin
            exp_t e;
            e = idle_out();
            e.valid = 1'b1;
            e.stp = k;
            for (int i = 0; i < N; i++) begin
              e.w[i*DW +: DW] = wm[m][i*N + k];
              e.x[i*DW +: DW] = xm[m][k*N + i];
            end
            pq[m].push_back(e);
          end
          begin
            exp_t e;
            e = idle_out();
            e.done = 1'b1;
            pq[m].push_back(e);
          end
        end
      end else begin
        if (lw) begin
          if (wc[m] < NN) begin wm[m][wc[m]] = d; wc[m]++; end
          else ovf_e[m] = 1'b1;
          if (lx) ovf_e[m] = 1'b1;
        end else if (lx) begin
          if (xc[m] < NN) begin xm[m][xc[m]] = d; xc[m]++; end
          else ovf_e[m] = 1'b1;
        end
        rdy[m] = (wc[m] == NN) && (xc[m] == NN);
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int m);
    string n;
    n = (m == 0) ? "a" : "b";
    check({n, ".load_ready"},  64'(lr[m]),  64'(!rdy[m] && pq[m].size() == 0));
    check({n, ".start"},       64'(st[m]),  64'(rdy[m]));
    check({n, ".w_full"},      64'(wf[m]),  64'(wc[m] == NN));
    check({n, ".x_full"},      64'(xf[m]),  64'(xc[m] == NN));
    check({n, ".overflow"},    64'(ov[m]),  64'(ovf_e[m]));
    check({n, ".out_valid"},   64'(ovl[m]), 64'(cur[m].valid));
    check({n, ".data_outw"},   64'(dw[m]),  64'(cur[m].w));
    check({n, ".data_outx"},   64'(dx[m]),  64'(cur[m].x));
    check({n, ".step"},        64'(sp[m]),  64'(cur[m].stp));
    check({n, ".unload_done"}, 64'(dn[m]),  64'(cur[m].done));
  endtask

  task automatic drive(input bit lw, input bit lx, input bit fl, input bit un,
                       input logic [DW-1:0] d);
    load_w = lw; load_x = lx; flush = fl; unload = un; data_in = d;
    @(posedge clk);
    model_edge(lw, lx, fl, un, d);
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    load_w = 1'b0; load_x = 1'b0; flush = 1'b0; unload = 1'b0; data_in = '0;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic rnd_fill();
    for (int i = 0; i < NN; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, DW'($urandom));
    for (int i = 0; i < NN; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, DW'($urandom));
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    clear_n = 1'b1;

    // First pass: W = 1..9, X = 9..1.
    for (int i = 1; i <= NN; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, DW'(i));
    for (int i = NN; i >= 1; i--) drive(1'b0, 1'b1, 1'b0, 1'b0, DW'(i));
    check("a.start_after_fill", 64'(st[0]), 64'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
    idle();
    check("a.step0_w", 64'(dw[0]), 64'h741);
    check("a.step0_x", 64'(dx[0]), 64'h789);
    idle();
    check("a.step1_w", 64'(dw[0]), 64'h852);
    check("a.step1_x", 64'(dx[0]), 64'h456);
    idle();
    check("a.step2_w", 64'(dw[0]), 64'h963);
    check("a.step2_x", 64'(dx[0]), 64'h123);
    idle();
    check("a.unload_done", 64'(dn[0]), 64'd1);
    check("a.w_full_rearm", 64'(wf[0]), 64'd0);
    check("b.w_kept", 64'(wf[1]), 64'd1);

    // Reload W on a; b keeps W so those loads overflow. Then a tenth W load on a.
    for (int i = 1; i <= NN; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, DW'(i));
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'hF);
    check("a.tenth_load_ovf", 64'(ov[0]), 64'd1);
    check("a.w_full_held", 64'(wf[0]), 64'd1);
    for (int i = 1; i <= NN; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, DW'(i));
    check("b.start_x_only", 64'(st[1]), 64'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
    idle();
    check("b.step0_w", 64'(dw[1]), 64'h741);
    check("b.step0_x", 64'(dx[1]), 64'h321);
    check("a.step0_w_unchanged", 64'(dw[0]), 64'h741);
    repeat (3) idle();

    // Simultaneous W/X load: W wins, X dropped with overflow.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h5);
    check("a.both_ovf", 64'(ov[0]), 64'd1);

    // Half fill, then unload in FILL must be ignored.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, DW'($urandom));
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, DW'($urandom));
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("a.unload_in_fill_valid", 64'(ovl[0]), 64'd0);
    idle();
    check("a.unload_in_fill_ready", 64'(lr[0]), 64'd1);

    // Complete both, unload, flush during step 1.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, DW'($urandom));
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, DW'($urandom));
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
    idle();
    check("a.priority_w5", 64'(dw[0][DW-1:0]), 64'h5);
    idle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("a.flush_outw", 64'(dw[0]), 64'd0);
    check("a.flush_ready", 64'(lr[0]), 64'd1);
    check("b.flush_wfull", 64'(wf[1]), 64'd0);
    repeat (5) idle();

    // Same pass aborted by asynchronous reset during step 1.
    rnd_fill();
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
    idle();
    idle();
    clear_n = 1'b0;
    #1;
    model_reset();
    check_dut(0);
    check_dut(1);
    check("a.rst_valid", 64'(ovl[0]), 64'd0);
    check("a.rst_ready", 64'(lr[0]), 64'd1);
    @(negedge clk);
    clear_n = 1'b1;
    repeat (3) idle();

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      drive(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            ($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0), DW'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
